mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 23 ++
 rtl/mux_rr_arbiter_mux.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared constants, state encoding and round-robin pick helper
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First requesting index strictly after last, wrapping; lowest distance wins.
  function automatic logic [SELW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [SELW-1:0] last);
    logic [SELW-1:0] idx;
    rr_pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + SELW'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// rtl/mux_rr_arbiter_mux.sv - shared 4-bit 4:1 data mux
module mux (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning a shared 4-bit channel with hold limit
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int DW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   d0,
  input  logic [DW-1:0]   d1,
  input  logic [DW-1:0]   d2,
  input  logic [DW-1:0]   d3,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  output logic [NREQ-1:0] gnt,
  output logic [SELW-1:0] sel
);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [3:0]      hold_inc;
  logic [SELW-1:0] pick;
  logic            xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SELW'(NREQ - 1);
      gnt_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign pick     = rr_pick(req, last_q);
  assign hold_inc = hold_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (req != '0) begin
          state_d    = GRANT;
          sel_d      = pick;
          last_d     = pick;
          gnt_d      = NREQ'(1) << pick;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        // Withdrawal takes priority; a withdrawn owner cannot be transferring.
        if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (xfer) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == 4'(MAX_HOLD)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid = !rst && (state_q == GRANT) && req[sel_q];
    xfer      = out_valid && out_ready;
    gnt       = gnt_q;
    sel       = sel_q;
  end

  mux u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel_q),
    .y   (out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - randomized and directed checks against a behavioural channel-ownership model
module tb_mux_rr_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dv [4];
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic [3:0] gnt;
  logic [1:0] sel;

  int checks = 0;
  int errs   = 0;

  // model: who owns the channel, and how many transfers it has made
  int m_owner, m_last, m_sel, m_cnt;
  int waits [4];
  bit rand_d;

  mux_rr_arbiter #(.MAX_HOLD(MAXH), .DW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (dv[0]),
    .d1        (dv[1]),
    .d2        (dv[2]),
    .d3        (dv[3]),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .gnt       (gnt),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [3:0] eg;
    logic       ev;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    ev = !rst && (m_owner >= 0) && req[m_owner];
    check("gnt", gnt, eg);
    check("sel", sel, m_sel);
    check("out_valid", out_valid, ev);
    check("out_data", out_data, dv[m_sel]);
    check("gnt_onehot0", $onehot0(gnt), 1);
  endtask

  task automatic model_update();
    if (rst) begin
      m_owner = -1; m_sel = 0; m_cnt = 0; m_last = 3;
      for (int j = 0; j < 4; j++) waits[j] = 0;
      return;
    end
    for (int j = 0; j < 4; j++) if (!req[j]) waits[j] = 0;
    if (m_owner < 0) begin
      if (req != 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        end
        m_sel = m_owner; m_last = m_owner; m_cnt = 0;
        for (int j = 0; j < 4; j++) begin
          if (j == m_owner) waits[j] = 0;
          else if (req[j]) begin
            waits[j]++;
            check("wait_bound", waits[j] <= 3, 1);
          end
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (out_ready) begin
      m_cnt++;
      if (m_cnt == MAXH) m_owner = -1;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
    req = r; out_ready = rdy; rst = rs;
    if (rand_d) for (int i = 0; i < 4; i++) dv[i] = 4'($urandom);
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b0, 1'b1);
  endtask

  int exp029 [12] = '{0, 1, 1, 1, 1, 0, 4, 4, 4, 4, 0, 1};
  int exp030 [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int nx;

  initial begin
    rand_d = 0;
    rst = 1'b1; req = '0; out_ready = 1'b0;
    dv[0] = 4'h1; dv[1] = 4'h5; dv[2] = 4'h7; dv[3] = 4'hA;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // reset state
    do_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 2'd0);

    // two requesters alternate with a bubble
    for (int c = 0; c < 12; c++) begin
      check("alt_gnt", gnt, exp029[c]);
      step(4'b0101, 1'b1, 1'b0);
    end

    // single continuous requester 3
    do_reset();
    for (int c = 0; c < 11; c++) begin
      check("solo_valid", out_valid, exp030[c]);
      if (exp030[c] == 1) check("solo_data", out_data, 4'hA);
      step(4'b1000, 1'b1, 1'b0);
    end

    // backpressure on owner 2
    do_reset();
    step(4'b0100, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(4'b0100, 1'b0, 1'b0);
      check("bp_gnt", gnt, 4'b0100);
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 4'h7);
    end
    nx = 0;
    for (int c = 0; c < 10; c++) begin
      if (gnt == 4'b0100 && nx == c) nx++;
      step(4'b0100, 1'b1, 1'b0);
    end
    check("bp_full_hold", nx, MAXH);

    // owner 1 withdraws after two transfers
    do_reset();
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    check("wd_owner1", gnt, 4'b0010);
    step(4'b1000, 1'b1, 1'b0);
    check("wd_idle_gnt", gnt, 4'b0000);
    step(4'b1000, 1'b1, 1'b0);
    check("wd_gnt3", gnt, 4'b1000);
    check("wd_sel3", sel, 2'd3);

    // reset mid-grant
    do_reset();
    step(4'b1000, 1'b1, 1'b0);
    check("mr_gnt3", gnt, 4'b1000);
    step(4'b1111, 1'b1, 1'b1);
    check("mr_gnt0", gnt, 4'b0000);
    check("mr_sel0", sel, 2'd0);
    step(4'b1111, 1'b1, 1'b0);
    check("mr_first", gnt, 4'b0001);

    // random traffic
    do_reset();
    rand_d = 1;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) < 6);
      step(r, $urandom_range(0, 3) != 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
